tx_control_se: RTL and testbench

//  Transmit-side sequencer for the UART calculator link. On trigger_tx it captures the
//  ALU result and sends it as N_BYTES bytes, one at a time, to the byte-level UART

---
 rtl/tx_control_se.sv | 145 ++++++++++++++
 tb/tb_tx_control_se.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_control_se.sv
// Transmit-side sequencer: captures an N_BYTES-wide ALU result on trigger_tx and feeds it
// byte by byte to uart_tx using a tx_start / tx_busy handshake.
module tx_control_se #(
    parameter int N_BYTES    = 2,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESET,
    input  logic                   trigger_tx,
    input  logic [8*N_BYTES-1:0]   result,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   trig_overrun,
    output logic [2:0]             c_state
);

    localparam int W     = 8 * N_BYTES;
    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg,   idx_next;
    logic [GAP_W-1:0] gap_reg,   gap_next;
    logic [W-1:0]     shift_reg, shift_next;
    logic [7:0]       data_reg,  data_next;
    logic             ovr_reg,   ovr_next;

    // The byte to send next always sits at the "front" end of the shift register.
    function automatic logic [7:0] front_byte(input logic [W-1:0] v);
        if (MSB_FIRST)
            return v[W-1 -: 8];
        else
            return v[7:0];
    endfunction

    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        if (MSB_FIRST)
            return v << 8;
        else
            return v >> 8;
    endfunction

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            gap_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            gap_reg   <= gap_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        gap_next   = gap_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        // Any trigger outside IDLE is dropped, including the DONE cycle.
        ovr_next   = ovr_reg | (trigger_tx && (state_reg != IDLE));

        case (state_reg)
            IDLE: begin
                if (trigger_tx) begin
                    data_next  = front_byte(result);
                    shift_next = advance(result);
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                        if (GAP_CYCLES > 0) begin
                            gap_next   = GAP_INIT;
                            state_next = GAP;
                        end else begin
                            data_next  = front_byte(shift_reg);
                            shift_next = advance(shift_reg);
                            state_next = START;
                        end
                    end
                end
            end
            GAP: begin
                gap_next = gap_reg - GAP_ONE;
                if (gap_reg == GAP_ONE) begin
                    data_next  = front_byte(shift_reg);
                    shift_next = advance(shift_reg);
                    state_next = START;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_data      = data_reg;
    assign tx_start     = (state_reg == START);
    assign tx_done      = (state_reg == DONE);
    assign busy         = (state_reg != IDLE);
    assign trig_overrun = ovr_reg;
    assign c_state      = state_reg;

endmodule

// File: tb/tb_tx_control_se.sv
// Randomized bench for tx_control_se: four parameter variants share trigger/result/reset,
// each with its own uart_tx responder and a timeline-based reference model.
module tb_tx_control_se;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic [31:0] res;
    logic        busy_in [NI];
    logic [7:0]  data_o  [NI];
    logic        start_o [NI];
    logic        busy_o  [NI];
    logic        done_o  [NI];
    logic        ovr_o   [NI];
    logic [2:0]  st_o    [NI];

    always #5 clk = ~clk;

    tx_control_se #(.N_BYTES(2), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut0 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .trigger_tx(trig), .result(res[15:0]),
        .tx_busy(busy_in[0]), .tx_data(data_o[0]), .tx_start(start_o[0]), .busy(busy_o[0]),
        .tx_done(done_o[0]), .trig_overrun(ovr_o[0]), .c_state(st_o[0]));
    tx_control_se #(.N_BYTES(2), .MSB_FIRST(1'b1), .GAP_CYCLES(4)) dut1 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .trigger_tx(trig), .result(res[15:0]),
        .tx_busy(busy_in[1]), .tx_data(data_o[1]), .tx_start(start_o[1]), .busy(busy_o[1]),
        .tx_done(done_o[1]), .trig_overrun(ovr_o[1]), .c_state(st_o[1]));
    tx_control_se #(.N_BYTES(3), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) dut2 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .trigger_tx(trig), .result(res[23:0]),
        .tx_busy(busy_in[2]), .tx_data(data_o[2]), .tx_start(start_o[2]), .busy(busy_o[2]),
        .tx_done(done_o[2]), .trig_overrun(ovr_o[2]), .c_state(st_o[2]));
    tx_control_se #(.N_BYTES(1), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut3 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .trigger_tx(trig), .result(res[7:0]),
        .tx_busy(busy_in[3]), .tx_data(data_o[3]), .tx_start(start_o[3]), .busy(busy_o[3]),
        .tx_done(done_o[3]), .trig_overrun(ovr_o[3]), .c_state(st_o[3]));

    function automatic int nb_of(int i);
        case (i) 0: return 2; 1: return 2; 2: return 3; default: return 1; endcase
    endfunction
    function automatic bit msb_of(int i);
        return (i == 1) || (i == 3);
    endfunction
    function automatic int gap_of(int i);
        case (i) 0: return 0; 1: return 4; 2: return 1; default: return 2; endcase
    endfunction

    // Reference model: per instance, the cycle numbers of the current byte's events.
    int          cyc;
    bit          act [NI], pend [NI], last [NI], ovr_m [NI];
    int          start_c [NI], ack_c [NI], low_c [NI], nxt_c [NI], bi [NI];
    logic [31:0] cap [NI];
    logic [7:0]  hold [NI];

    int          n_vec, n_bad;
    bit          rst_req, trig_req, dir_t;
    logic [31:0] res_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(int i, int k);
        int pos;
        pos = msb_of(i) ? (nb_of(i) - 1 - k) : k;
        return 8'((cap[i] >> (8 * pos)) & 32'hFF);
    endfunction

    // A byte starts at cycle n: uart raises busy d cycles after the first WAIT_ACK cycle
    // and holds it for l cycles.
    task automatic sched(input int i, input int n);
        int d, l;
        d = dir_t ? 0  : int'($urandom_range(0, 3));
        l = dir_t ? 10 : int'($urandom_range(1, 12));
        start_c[i] = n;
        ack_c[i]   = n + 1 + d;
        low_c[i]   = ack_c[i] + l;
        last[i]    = (bi[i] == nb_of(i) - 1);
        nxt_c[i]   = low_c[i] + 1 + (last[i] ? 0 : gap_of(i));
        hold[i]    = byte_at(i, bi[i]);
    endtask

    task automatic check_outputs(input int i, input int est);
        chk($sformatf("d%0d.tx_start", i), 32'(start_o[i]), 32'(est == 1));
        chk($sformatf("d%0d.tx_done", i),  32'(done_o[i]),  32'(est == 5));
        chk($sformatf("d%0d.busy", i),     32'(busy_o[i]),  32'(est != 0));
        chk($sformatf("d%0d.overrun", i),  32'(ovr_o[i]),   32'(ovr_m[i]));
        chk($sformatf("d%0d.tx_data", i),  32'(data_o[i]),  32'(hold[i]));
        chk($sformatf("d%0d.c_state", i),  32'(st_o[i]),    32'(est));
    endtask

    task automatic cycle();
        int est;
        @(negedge clk);
        cyc++;
        if (rst_req) begin
            rst  = 1'b1;
            trig = 1'b1;
            res  = $urandom;
            for (int i = 0; i < NI; i++) busy_in[i] = 1'b1;
            #1;
            for (int i = 0; i < NI; i++) begin
                act[i] = 0; pend[i] = 0; ovr_m[i] = 0; hold[i] = 8'h00;
                check_outputs(i, 0);
            end
        end else begin
            rst = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (pend[i] && cyc == start_c[i]) begin
                    pend[i] = 0;
                    act[i]  = 1;
                    sched(i, cyc);
                end else if (act[i] && cyc == nxt_c[i] && !last[i]) begin
                    bi[i]++;
                    sched(i, cyc);
                end
                if (!act[i])                  est = 0;
                else if (cyc == start_c[i])   est = 1;
                else if (cyc <= ack_c[i])     est = 2;
                else if (cyc <= low_c[i])     est = 3;
                else if (cyc == nxt_c[i] && last[i]) est = 5;
                else                          est = 4;
                check_outputs(i, est);
                busy_in[i] = act[i] && (cyc >= ack_c[i]) && (cyc < low_c[i]);
                if (trig_req) begin
                    if (est == 0) begin
                        pend[i]    = 1;
                        start_c[i] = cyc + 1;
                        bi[i]      = 0;
                        cap[i]     = res_req & ((32'h1 << (8 * nb_of(i))) - 32'h1);
                    end else begin
                        ovr_m[i] = 1;
                    end
                end
                if (est == 5) act[i] = 0;
            end
            trig = trig_req;
            res  = res_req;
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++)
            if (act[i] || pend[i]) return 0;
        return 1;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (!all_idle() && k < 500) begin
            cycle();
            k++;
        end
        chk("idle_wait_budget", 32'(k < 500), 32'd1);
    endtask

    task automatic fire(input logic [31:0] v);
        res_req  = v;
        trig_req = 1;
        cycle();
        trig_req = 0;
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0; res = '0;
        for (int i = 0; i < NI; i++) begin
            busy_in[i] = 1'b0; act[i] = 0; pend[i] = 0; ovr_m[i] = 0; hold[i] = 8'h00;
            bi[i] = 0; cap[i] = '0; last[i] = 0;
            start_c[i] = 0; ack_c[i] = 0; low_c[i] = 0; nxt_c[i] = 0;
        end
        cyc = 0; n_vec = 0; n_bad = 0;
        rst_req = 1; trig_req = 0; dir_t = 0; res_req = '0;

        repeat (3) cycle();
        rst_req = 0;
        repeat (10) cycle();

        for (int ep = 0; ep < 6; ep++) begin
            for (int t = 0; t < 6; t++) begin
                wait_idle();
                dir_t = (ep == 0 && t == 0);
                if (ep == 0 && t == 0)      fire(32'h0000A53C);
                else if (ep == 0 && t == 1) fire(32'h00001234);
                else if (t == 0)            fire(32'h000000FF);
                else                        fire($urandom);
                if (ep >= 1 && $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 20)) cycle();
                    fire($urandom);
                end
            end
            // Reset lands somewhere inside a running sequence.
            wait_idle();
            dir_t = 0;
            fire($urandom);
            repeat ($urandom_range(5, 30)) cycle();
            rst_req = 1;
            repeat (2) cycle();
            rst_req = 0;
            repeat (10) cycle();
        end
        wait_idle();
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
